// File: rtl/updown_pwm_pkg.sv
// Shared types and constants for the center-aligned PWM generator.
package updown_pwm_pkg;

  localparam int unsigned W_DEF    = 8;
  localparam int unsigned DT_W_DEF = 4;

  typedef enum logic [1:0] {
    S_LO    = 2'd0,
    S_DT_UP = 2'd1,
    S_HI    = 2'd2,
    S_DT_DN = 2'd3
  } state_t;

  // Leave reset in a dead window so neither side drives on reset exit.
  localparam state_t RST_STATE = S_DT_DN;

  typedef struct packed {
    logic [W_DEF-1:0]    duty;
    logic [DT_W_DEF-1:0] dt;
  } cfg_t;

endpackage

// File: rtl/updown_deadtime.sv
// Dead-time inserter: turns the raw compare into complementary drives.
module updown_deadtime
  import updown_pwm_pkg::*;
#(
  parameter int unsigned DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            raw,
  input  logic [DT_W-1:0] dt_act,
  output logic            out_hi,
  output logic            out_lo
);

  state_t          state;
  state_t          state_nxt;
  logic [DT_W-1:0] dt_cnt;
  logic [DT_W-1:0] dt_cnt_nxt;

  // State, dead-time counter and decoded drive registers.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state  <= RST_STATE;
      dt_cnt <= '1;
      out_hi <= 1'b0;
      out_lo <= 1'b0;
    end else begin
      state  <= state_nxt;
      dt_cnt <= dt_cnt_nxt;
      out_hi <= (state_nxt == S_HI);
      out_lo <= (state_nxt == S_LO);
    end
  end

  // Next-state logic; a raw reversal during dead time aborts back to the old side.
  always_comb begin
    state_nxt  = state;
    dt_cnt_nxt = dt_cnt;
    case (state)
      S_LO: begin
        if (raw) begin
          if (dt_act == '0) begin
            state_nxt = S_HI;
          end else begin
            state_nxt  = S_DT_UP;
            dt_cnt_nxt = dt_act;
          end
        end
      end
      S_DT_UP: begin
        if (!raw) begin
          state_nxt = S_LO;
        end else if (dt_cnt == DT_W'(1)) begin
          state_nxt = S_HI;
        end else begin
          dt_cnt_nxt = dt_cnt - DT_W'(1);
        end
      end
      S_HI: begin
        if (!raw) begin
          if (dt_act == '0) begin
            state_nxt = S_LO;
          end else begin
            state_nxt  = S_DT_DN;
            dt_cnt_nxt = dt_act;
          end
        end
      end
      S_DT_DN: begin
        if (raw) begin
          state_nxt = S_HI;
        end else if (dt_cnt == DT_W'(1)) begin
          state_nxt = S_LO;
        end else begin
          dt_cnt_nxt = dt_cnt - DT_W'(1);
        end
      end
      default: begin
        state_nxt = RST_STATE;
      end
    endcase
  end

endmodule

// File: rtl/updown_pwm.sv
// Center-aligned PWM: valley-synchronous double-buffered duty/dead-time plus compare.
module updown_pwm
  import updown_pwm_pkg::*;
#(
  parameter int unsigned W    = W_DEF,
  parameter int unsigned DT_W = DT_W_DEF
) (
  input  logic            clk,
  input  logic            nrst,
  input  logic            en,
  input  logic [W-1:0]    q,
  input  logic            cfg_valid,
  output logic            cfg_ready,
  input  logic [W-1:0]    cfg_duty,
  input  logic [DT_W-1:0] cfg_dt,
  output logic            out_hi,
  output logic            out_lo,
  output logic            period_start
);

  typedef struct packed {
    logic [W-1:0]    duty;
    logic [DT_W-1:0] dt;
  } cfg_w_t;

  cfg_w_t pend;
  cfg_w_t act;
  logic   raw_c;
  logic   valley_c;
  logic   accept_c;

  assign raw_c    = (q < act.duty);
  assign valley_c = en && (q == '0);
  assign accept_c = cfg_valid && cfg_ready;

  // Pending/active buffers; cfg_ready doubles as the pending-empty flag.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      pend.duty    <= '0;
      pend.dt      <= '0;
      act.duty     <= '0;
      act.dt       <= '1;
      cfg_ready    <= 1'b1;
      period_start <= 1'b0;
    end else begin
      period_start <= valley_c;
      if (accept_c) begin
        pend.duty <= cfg_duty;
        pend.dt   <= cfg_dt;
      end
      // Load needs a full buffer and accept needs an empty one, so they never collide.
      if (valley_c && !cfg_ready) begin
        act       <= pend;
        cfg_ready <= 1'b1;
      end else if (accept_c) begin
        cfg_ready <= 1'b0;
      end
    end
  end

  updown_deadtime #(
    .DT_W (DT_W)
  ) u_deadtime (
    .clk    (clk),
    .nrst   (nrst),
    .raw    (raw_c),
    .dt_act (act.dt),
    .out_hi (out_hi),
    .out_lo (out_lo)
  );

endmodule

// File: tb/tb_updown_pwm.sv
// Directed bench for updown_pwm with a behavioural triangle counter (W=4, period 30).
module tb_updown_pwm;

  localparam int unsigned W    = 4;
  localparam int unsigned DT_W = 4;

  logic            clk = 1'b0;
  logic            nrst;
  logic            en;
  logic [W-1:0]    q;
  logic            up;
  logic            cfg_valid;
  logic            cfg_ready;
  logic [W-1:0]    cfg_duty;
  logic [DT_W-1:0] cfg_dt;
  logic            out_hi;
  logic            out_lo;
  logic            period_start;

  int checks   = 0;
  int passes   = 0;
  int both_cnt = 0;

  updown_pwm #(
    .W    (W),
    .DT_W (DT_W)
  ) dut (
    .clk          (clk),
    .nrst         (nrst),
    .en           (en),
    .q            (q),
    .cfg_valid    (cfg_valid),
    .cfg_ready    (cfg_ready),
    .cfg_duty     (cfg_duty),
    .cfg_dt       (cfg_dt),
    .out_hi       (out_hi),
    .out_lo       (out_lo),
    .period_start (period_start)
  );

  always #5 clk = ~clk;

  // Upstream up/down triangle counter: 0..15..1, 0, ...
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      q  <= '0;
      up <= 1'b1;
    end else if (en) begin
      if (up) begin
        if (q == 4'(15)) begin
          q  <= 4'(14);
          up <= 1'b0;
        end else begin
          q <= q + 4'(1);
        end
      end else begin
        if (q == 4'(0)) begin
          q  <= 4'(1);
          up <= 1'b1;
        end else begin
          q <= q - 4'(1);
        end
      end
    end
  end

  // Overlap monitor for the complementary drives.
  always @(negedge clk) begin
    if (out_hi && out_lo) both_cnt++;
  end

  task automatic chk(input string tag, input int got, input int exp);
    checks++;
    if (got == exp) passes++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic run(input int n, output int hi, output int lo, output int ps);
    hi = 0; lo = 0; ps = 0;
    repeat (n) begin
      @(negedge clk);
      hi += int'(out_hi);
      lo += int'(out_lo);
      ps += int'(period_start);
    end
  endtask

  task automatic wait_ps(input string tag, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!period_start && n < 100);
    chk({tag, "_ps"}, int'(period_start), 1);
  endtask

  // Offers one config word; ps_seen is period_start on the cycle ready was seen.
  task automatic cfg_write(input logic [W-1:0] d, input logic [DT_W-1:0] t, output int ps_seen);
    int waited;
    @(negedge clk);
    cfg_valid = 1'b1;
    cfg_duty  = d;
    cfg_dt    = t;
    waited    = 0;
    while (!cfg_ready && waited < 100) begin
      @(negedge clk);
      waited++;
    end
    chk("wr_ready_seen", int'(cfg_ready), 1);
    ps_seen = int'(period_start);
    @(negedge clk);
    cfg_valid = 1'b0;
  endtask

  initial begin
    int hi, lo, ps, n, rdy, pss;
    nrst = 1'b1; en = 1'b1; cfg_valid = 1'b0; cfg_duty = '0; cfg_dt = '0;
    #2 nrst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_out_hi", int'(out_hi), 0);
    chk("rst_out_lo", int'(out_lo), 0);
    chk("rst_period_start", int'(period_start), 0);
    chk("rst_cfg_ready", int'(cfg_ready), 1);

    // Idle after reset: 15-cycle dead window at dt=15, then low side on.
    nrst = 1'b1;
    run(30, hi, lo, ps);
    chk("idle1_hi", hi, 0);
    chk("idle1_lo", lo, 16);
    chk("idle1_ps", ps, 1);
    run(30, hi, lo, ps);
    chk("idle2_hi", hi, 0);
    chk("idle2_lo", lo, 30);
    chk("idle2_ps", ps, 1);
    chk("idle_ready", int'(cfg_ready), 1);

    // duty=8 dt=2
    cfg_write(4'(8), 4'(2), pss);
    chk("d8_ready_low", int'(cfg_ready), 0);
    wait_ps("d8_load", n);
    chk("d8_ready_back", int'(cfg_ready), 1);
    run(30, hi, lo, ps);
    run(30, hi, lo, ps);
    chk("d8_hi", hi, 13);
    chk("d8_lo", lo, 13);
    chk("d8_ps", ps, 1);

    // duty=15: high side drops for one cycle at the peak
    cfg_write(4'(15), 4'(2), pss);
    wait_ps("d15_load", n);
    run(30, hi, lo, ps);
    run(30, hi, lo, ps);
    chk("d15_hi", hi, 29);
    chk("d15_lo", lo, 0);

    // duty=0: low side constant
    cfg_write(4'(0), 4'(2), pss);
    wait_ps("d0_load", n);
    run(30, hi, lo, ps);
    run(30, hi, lo, ps);
    chk("d0_hi", hi, 0);
    chk("d0_lo", lo, 30);

    // Back-to-back: 8 then 4; 4 is held until 8 loads at a valley.
    cfg_write(4'(8), 4'(2), pss);
    cfg_write(4'(4), 4'(2), pss);
    chk("b2b_accept_at_valley", pss, 1);
    n = 0; hi = 0; rdy = 0;
    do begin
      @(negedge clk);
      if (!period_start) begin
        hi  += int'(out_hi);
        rdy += int'(cfg_ready);
      end
      n++;
    end while (!period_start && n < 60);
    chk("b2b_gap", n, 29);
    chk("b2b_d8_hi", hi, 10);
    chk("b2b_ready_held", rdy, 0);
    chk("b2b_ready_back", int'(cfg_ready), 1);
    run(30, hi, lo, ps);
    run(30, hi, lo, ps);
    chk("d4_hi", hi, 5);
    chk("d4_lo", lo, 21);

    // Write accepted on the valley edge itself loads one period later.
    n = 0;
    while (q != 4'(0) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("co_found_valley", int'(q == 4'(0)), 1);
    cfg_valid = 1'b1; cfg_duty = 4'(8); cfg_dt = 4'(2);
    @(negedge clk);
    cfg_valid = 1'b0;
    chk("co_ps", int'(period_start), 1);
    chk("co_ready_low", int'(cfg_ready), 0);
    wait_ps("co_load", n);
    chk("co_gap", n, 30);
    chk("co_ready_back", int'(cfg_ready), 1);
    run(30, hi, lo, ps);
    run(30, hi, lo, ps);
    chk("co_hi", hi, 13);
    chk("co_lo", lo, 13);

    // en=0 at q=8 rising: dead-time completes, then hold; no valley, no load.
    n = 0;
    while (!(q == 4'(8) && up) && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("en_found_q8", int'(q == 4'(8) && up), 1);
    en = 1'b0;
    hi = 0; lo = 0; ps = 0;
    for (int i = 1; i <= 50; i++) begin
      @(negedge clk);
      if (i == 1) chk("en_hi_drop", int'(out_hi), 0);
      hi += int'(out_hi);
      if (i >= 3) lo += int'(out_lo);
      ps += int'(period_start);
      if (i == 10) begin
        cfg_valid = 1'b1; cfg_duty = 4'(0); cfg_dt = 4'(2);
      end
      if (i == 11) cfg_valid = 1'b0;
    end
    chk("en_hi", hi, 0);
    chk("en_lo_hold", lo, 48);
    chk("en_no_ps", ps, 0);
    chk("en_pending_kept", int'(cfg_ready), 0);
    en = 1'b1;
    wait_ps("en_resume", n);
    chk("en_resume_gap", n, 23);
    chk("en_resume_ready", int'(cfg_ready), 1);
    run(30, hi, lo, ps);
    run(30, hi, lo, ps);
    chk("en_d0_hi", hi, 0);
    chk("en_d0_lo", lo, 30);

    // Reset while high side is on and pending is full.
    cfg_write(4'(8), 4'(2), pss);
    wait_ps("rs_load", n);
    cfg_write(4'(4), 4'(2), pss);
    n = 0;
    while (!out_hi && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("rs_in_hi", int'(out_hi), 1);
    nrst = 1'b0;
    #1;
    chk("rs_out_hi", int'(out_hi), 0);
    chk("rs_out_lo", int'(out_lo), 0);
    chk("rs_ready", int'(cfg_ready), 1);
    chk("rs_ps", int'(period_start), 0);
    repeat (2) @(negedge clk);
    nrst = 1'b1;
    run(60, hi, lo, ps);
    chk("rs_after_hi", hi, 0);
    chk("rs_after_lo", lo, 46);
    chk("rs_after_ps", ps, 2);
    chk("rs_after_ready", int'(cfg_ready), 1);

    chk("never_both", both_cnt, 0);
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
